pred_ctx_sequencer: RTL

- Per-PE context sequencer that drives every control input of the predicate register file (pred_reg2) from a small context memory, one context word per cycle.
- The host loads the memory through a config write port, then pulses start. The block steps contexts 0..last, repeats the sequence loop_cnt+1 times, supports stall, and signals done.
- It sits between the CGRA configuration bus and pred_reg2 inside each PE.

---
 rtl/pred_ctx_pkg.sv | 31 +++
 rtl/pred_ctx_sequencer.sv | 136 +++++++++++++
 2 files changed

// File: rtl/pred_ctx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pred_ctx_pkg
// Purpose  : Context word layout, NOP word and FSM encoding for the
//            predicate context sequencer.
// Revision : 1.0
// ============================================================================
package pred_ctx_pkg;

    localparam int CTX_W     = 48;

    localparam int P_LAST    = 47;
    localparam int P_WB      = 46;
    localparam int P_PE2FU   = 42;
    localparam int P_IN      = 33;
    localparam int P_OUT     = 24;
    localparam int P_PUT_IN  = 18;
    localparam int P_PUT_OUT = 12;
    localparam int P_PRED    = 6;
    localparam int P_SEND    = 0;

    localparam logic [CTX_W-1:0] CTX_NOP = '0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/pred_ctx_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pred_ctx_sequencer
// Purpose  : Steps a small context memory and drives the pred_reg2 controls,
//            one context word per cycle, with looping, stall and done.
// Revision : 1.0
// ============================================================================
module pred_ctx_sequencer
    import pred_ctx_pkg::*;
#(
    parameter int CTX_DEPTH = 16,
    parameter int CTX_AW    = 4,
    parameter int PRED_AW   = 6
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               cfg_we,
    input  logic [CTX_AW-1:0]  cfg_addr,
    input  logic [CTX_W-1:0]   cfg_data,
    output logic               cfg_err,
    input  logic               start,
    input  logic [7:0]         loop_cnt,
    input  logic               stall,
    output logic               busy,
    output logic               done,
    output logic [CTX_AW-1:0]  ctx_ptr,
    output logic               write_back_p,
    output logic [8:0]         control_in_p,
    output logic [8:0]         control_out_p,
    output logic [PRED_AW-1:0] control_put_in_p,
    output logic [PRED_AW-1:0] control_put_out_p,
    output logic [PRED_AW-1:0] control_pred,
    output logic [PRED_AW-1:0] control_send_p,
    output logic [3:0]         control_pe2fu_p
);

    localparam logic [CTX_AW-1:0] LAST_IDX = CTX_AW'(CTX_DEPTH - 1);

    logic [CTX_W-1:0]  mem [CTX_DEPTH];

    state_t            state,   state_n;
    logic [CTX_AW-1:0] ptr,     ptr_n;
    logic [7:0]        iter,    iter_n;
    logic [CTX_W-2:0]  ctl,     ctl_n;
    logic [CTX_AW-1:0] cur,     cur_n;
    logic              done_q,  done_n;
    logic              err_q,   err_n;
    logic [CTX_W-1:0]  word;

    assign busy = (state == ST_RUN);
    assign word = mem[ptr];

    // Memory is deliberately not reset; the host reloads it as needed.
    always_ff @(posedge CLK) begin
        if (cfg_we && !busy) begin
            mem[cfg_addr] <= cfg_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state  <= ST_IDLE;
            ptr    <= '0;
            iter   <= '0;
            ctl    <= CTX_NOP[CTX_W-2:0];
            cur    <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_n;
            ptr    <= ptr_n;
            iter   <= iter_n;
            ctl    <= ctl_n;
            cur    <= cur_n;
            done_q <= done_n;
            err_q  <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        iter_n  = iter;
        ctl_n   = CTX_NOP[CTX_W-2:0];
        cur_n   = cur;
        done_n  = 1'b0;
        err_n   = cfg_we && busy;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    iter_n  = loop_cnt;
                    ptr_n   = '0;
                    state_n = ST_RUN;
                end
            end
            ST_RUN: begin
                // A stalled cycle issues NOP and leaves the pointer parked.
                if (!stall) begin
                    ctl_n = word[CTX_W-2:0];
                    cur_n = ptr;
                    if (word[P_LAST] || (ptr == LAST_IDX)) begin
                        if (iter != 8'd0) begin
                            iter_n = iter - 8'd1;
                            ptr_n  = '0;
                        end else begin
                            state_n = ST_FIN;
                        end
                    end else begin
                        ptr_n = ptr + CTX_AW'(1);
                    end
                end
            end
            ST_FIN: begin
                done_n  = 1'b1;
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    assign done              = done_q;
    assign cfg_err           = err_q;
    assign ctx_ptr           = cur;
    assign write_back_p      = ctl[P_WB];
    assign control_pe2fu_p   = ctl[P_PE2FU +: 4];
    assign control_in_p      = ctl[P_IN +: 9];
    assign control_out_p     = ctl[P_OUT +: 9];
    assign control_put_in_p  = PRED_AW'(ctl[P_PUT_IN +: 6]);
    assign control_put_out_p = PRED_AW'(ctl[P_PUT_OUT +: 6]);
    assign control_pred      = PRED_AW'(ctl[P_PRED +: 6]);
    assign control_send_p    = PRED_AW'(ctl[P_SEND +: 6]);

endmodule
`default_nettype wire
